wb_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: ALU results and memory-load results.
- Round-robin arbitration with valid/ready handshakes.
- Registers the winning write so rf_write, rf_rdst and rf_data are stable before the register file's negedge write.
- Keeps a per-register busy scoreboard for issue-stage hazard checks.

---
 rtl/wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Shares the register file's single write port between the ALU and the
//   load unit. Round-robin grant on valid/ready. The winning write is
//   registered so rf_write/rf_rdst/rf_data are stable ahead of the
//   register file's negedge capture. Also tracks a per-register busy
//   scoreboard used by the issue stage for hazard checks.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   wb_stall                    suppresses all grants this cycle
//   alu_valid/rdst/data, alu_ready   ALU writeback request / grant
//   mem_valid/rdst/data, mem_ready   load writeback request / grant
//   claim_valid, claim_rdst     issue stage reserves a destination register
//   rf_write, rf_rdst, rf_data  registered write to the register file
//   busy                        bit n set while a write to rn is outstanding
//   claim_conflict              one-cycle pulse: claim hit an already-busy reg
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int REGWIDTH  = 4,
    parameter int DATAWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_stall,
    input  logic                   alu_valid,
    input  logic [REGWIDTH-1:0]    alu_rdst,
    input  logic [DATAWIDTH-1:0]   alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [REGWIDTH-1:0]    mem_rdst,
    input  logic [DATAWIDTH-1:0]   mem_data,
    output logic                   mem_ready,
    input  logic                   claim_valid,
    input  logic [REGWIDTH-1:0]    claim_rdst,
    output logic                   rf_write,
    output logic [REGWIDTH-1:0]    rf_rdst,
    output logic [DATAWIDTH-1:0]   rf_data,
    output logic [2**REGWIDTH-1:0] busy,
    output logic                   claim_conflict
);

    localparam int NREG = 2**REGWIDTH;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t                 last_grant_reg;
    logic                   rf_write_reg;
    logic [REGWIDTH-1:0]    rf_rdst_reg;
    logic [DATAWIDTH-1:0]   rf_data_reg;
    logic [NREG-1:0]        busy_reg;
    logic [NREG-1:0]        busy_next;
    logic                   claim_conflict_reg;

    logic                   alu_hs;
    logic                   mem_hs;
    logic                   any_hs;
    logic [REGWIDTH-1:0]    win_rdst;
    logic [DATAWIDTH-1:0]   win_data;
    logic                   conflict_next;

    // Grant: a lone requester always wins; on contention the side that did
    // not win last time goes. Both readies are forced low during a stall.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!wb_stall) begin
            if (alu_valid && mem_valid) begin
                alu_ready = (last_grant_reg == GRANT_MEM);
                mem_ready = (last_grant_reg == GRANT_ALU);
            end else begin
                alu_ready = alu_valid;
                mem_ready = mem_valid;
            end
        end
    end

    assign alu_hs   = alu_valid & alu_ready;
    assign mem_hs   = mem_valid & mem_ready;
    assign any_hs   = alu_hs | mem_hs;
    assign win_rdst = alu_hs ? alu_rdst : mem_rdst;
    assign win_data = alu_hs ? alu_data : mem_data;

    // Per-register busy bits. The set term is ORed in after the clear so a
    // claim and a writeback to the same register in one cycle leaves it busy.
    // r0 is hard-wired idle: its writes never retire anything and claims to
    // it are meaningless.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_r0
                assign busy_next[gi] = 1'b0;
            end else begin : g_rn
                logic set_bit;
                logic clr_bit;
                assign set_bit       = claim_valid && (claim_rdst == REGWIDTH'(gi));
                assign clr_bit       = any_hs && (win_rdst == REGWIDTH'(gi));
                assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
            end
        end
    endgenerate

    // A claim is only a conflict if the register stays busy through this
    // edge, i.e. it is not being retired by the same-cycle writeback.
    assign conflict_next = claim_valid && (claim_rdst != '0) && busy_reg[claim_rdst]
                           && !(any_hs && (win_rdst == claim_rdst));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg     <= GRANT_MEM;
            rf_write_reg       <= 1'b0;
            rf_rdst_reg        <= '0;
            rf_data_reg        <= '0;
            busy_reg           <= '0;
            claim_conflict_reg <= 1'b0;
        end else begin
            rf_write_reg       <= any_hs && (win_rdst != '0);
            busy_reg           <= busy_next;
            claim_conflict_reg <= conflict_next;
            if (any_hs) begin
                last_grant_reg <= alu_hs ? GRANT_ALU : GRANT_MEM;
                rf_rdst_reg    <= win_rdst;
                rf_data_reg    <= win_data;
            end
        end
    end

    assign rf_write       = rf_write_reg;
    assign rf_rdst        = rf_rdst_reg;
    assign rf_data        = rf_data_reg;
    assign busy           = busy_reg;
    assign claim_conflict = claim_conflict_reg;

endmodule
